// File: rtl/gfx_pkg.sv
// Shared definitions for the 64-bit pixel datapath: colour depth encodings
// and the reader's state encoding.
package gfx_pkg;

   localparam logic [2:0] DEPTH_8  = 3'd1;
   localparam logic [2:0] DEPTH_16 = 3'd3;
   localparam logic [2:0] DEPTH_32 = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_PIX = 2'd1,
      RD_Z   = 2'd2
   } reader_state_t;

endpackage

// File: rtl/gfx_pixel_reader64_if.sv
// 64-bit wishbone read port of the pixel reader.
// Handshake: read_o is a one-cycle strobe with read_addr_o/read_sel_o valid;
// the slave later raises ack_i for one cycle with dat_i valid in that cycle.
interface gfx_pixel_reader64_if;
   logic        read_o;
   logic [31:3] read_addr_o;
   logic [7:0]  read_sel_o;
   logic        ack_i;
   logic [63:0] dat_i;

   modport master (output read_o, read_addr_o, read_sel_o,
                   input  ack_i, dat_i);
   modport slave  (input  read_o, read_addr_o, read_sel_o,
                   output ack_i, dat_i);
endinterface

// File: rtl/memory_to_color64.sv
// Picks one little-endian pixel lane out of a 64-bit memory word and
// produces the byte selects that address that lane.
module memory_to_color64
   import gfx_pkg::*;
(
   input  logic [2:0]  color_depth,
   input  logic [2:0]  x_lsb,
   input  logic [63:0] mem,
   output logic [31:0] color,
   output logic [7:0]  sel
);

   always_comb begin
      color = mem[31:0];
      sel   = 8'h0F;
      unique case (color_depth)
         DEPTH_8: begin
            color = {24'h0, mem[{x_lsb, 3'b000} +: 8]};
            sel   = 8'h01 << x_lsb;
         end
         DEPTH_16: begin
            color = {16'h0, mem[{x_lsb[1:0], 4'b0000} +: 16]};
            sel   = 8'h03 << {x_lsb[1:0], 1'b0};
         end
         DEPTH_32: begin
            color = mem[{x_lsb[0], 5'b00000} +: 32];
            sel   = 8'h0F << {x_lsb[0], 2'b00};
         end
         default: begin
            color = mem[31:0];
            sel   = 8'h0F;
         end
      endcase
   end

endmodule

// File: rtl/gfx_pixel_reader64.sv
// Fetches a pixel's colour (and optionally its z value) over the 64-bit
// wishbone read port and returns them with a one-cycle ack.
module gfx_pixel_reader64
   import gfx_pkg::*;
#(
   parameter int point_width = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [31:3]            target_base_i,
   input  logic [31:3]            zbuffer_base_i,
   input  logic [point_width-1:0] target_size_x_i,
   input  logic [2:0]             color_depth_i,
   input  logic [point_width-1:0] pixel_x_i,
   input  logic [point_width-1:0] pixel_y_i,
   input  logic                   zbuffer_enable_i,
   input  logic                   read_i,
   gfx_pixel_reader64_if.master   wbm,
   output logic                   ack_o,
   output logic [31:0]            color_o,
   output logic [point_width-1:0] z_o,
   output reader_state_t          state_o
);

   reader_state_t          r_state, w_state_nxt;
   logic [point_width-1:0] r_x, r_y;
   logic [2:0]             r_depth;
   logic                   r_zen;
   logic                   r_read, w_read_nxt;
   logic [31:3]            r_addr, w_addr_nxt;
   logic [7:0]             r_sel, w_sel_nxt;
   logic                   r_ack, w_ack_nxt;
   logic [31:0]            r_color, w_color_nxt;
   logic [point_width-1:0] r_z, w_z_nxt;

   logic [point_width-1:0] w_x, w_y;
   logic [2:0]             w_depth;
   logic [31:0]            w_lin, w_pix_off, w_z_off;
   logic [31:3]            w_pix_addr, w_z_addr;
   logic [31:0]            w_pix_color, w_z_color;
   logic [7:0]             w_pix_sel, w_z_sel;

   // In IDLE the live inputs drive the address path so the strobe can go out
   // the cycle after read_i; afterwards the captured request is used.
   assign w_x     = (r_state == IDLE) ? pixel_x_i     : r_x;
   assign w_y     = (r_state == IDLE) ? pixel_y_i     : r_y;
   assign w_depth = (r_state == IDLE) ? color_depth_i : r_depth;

   assign w_lin = 32'(target_size_x_i) * 32'(w_y) + 32'(w_x);

   always_comb begin
      w_pix_off = 32'h0;
      unique case (w_depth)
         DEPTH_8:  w_pix_off = w_lin;
         DEPTH_16: w_pix_off = w_lin << 1;
         DEPTH_32: w_pix_off = w_lin << 2;
         default:  w_pix_off = 32'h0;
      endcase
   end

   assign w_z_off    = w_lin << 1;
   assign w_pix_addr = target_base_i  + 29'(w_pix_off >> 3);
   assign w_z_addr   = zbuffer_base_i + 29'(w_z_off >> 3);

   memory_to_color64 u_pix_lane (
      .color_depth (w_depth),
      .x_lsb       (w_x[2:0]),
      .mem         (wbm.dat_i),
      .color       (w_pix_color),
      .sel         (w_pix_sel)
   );

   memory_to_color64 u_z_lane (
      .color_depth (DEPTH_16),
      .x_lsb       (w_x[2:0]),
      .mem         (wbm.dat_i),
      .color       (w_z_color),
      .sel         (w_z_sel)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_read_nxt  = 1'b0;
      w_ack_nxt   = 1'b0;
      w_addr_nxt  = r_addr;
      w_sel_nxt   = r_sel;
      w_color_nxt = r_color;
      w_z_nxt     = r_z;
      unique case (r_state)
         IDLE: begin
            if (read_i) begin
               w_state_nxt = RD_PIX;
               w_read_nxt  = 1'b1;
               w_addr_nxt  = w_pix_addr;
               w_sel_nxt   = w_pix_sel;
            end
         end
         RD_PIX: begin
            if (wbm.ack_i) begin
               w_color_nxt = w_pix_color;
               if (r_zen) begin
                  w_state_nxt = RD_Z;
                  w_read_nxt  = 1'b1;
                  w_addr_nxt  = w_z_addr;
                  w_sel_nxt   = w_z_sel;
               end else begin
                  w_state_nxt = IDLE;
                  w_ack_nxt   = 1'b1;
                  w_z_nxt     = '0;
               end
            end
         end
         RD_Z: begin
            if (wbm.ack_i) begin
               w_state_nxt = IDLE;
               w_ack_nxt   = 1'b1;
               w_z_nxt     = point_width'(w_z_color);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_read  <= 1'b0;
         r_ack   <= 1'b0;
         r_addr  <= '0;
         r_sel   <= '0;
         r_color <= '0;
         r_z     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_read  <= w_read_nxt;
         r_ack   <= w_ack_nxt;
         r_addr  <= w_addr_nxt;
         r_sel   <= w_sel_nxt;
         r_color <= w_color_nxt;
         r_z     <= w_z_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_x     <= '0;
         r_y     <= '0;
         r_depth <= '0;
         r_zen   <= 1'b0;
      end else if (r_state == IDLE && read_i) begin
         r_x     <= pixel_x_i;
         r_y     <= pixel_y_i;
         r_depth <= color_depth_i;
         r_zen   <= zbuffer_enable_i;
      end
   end

   assign wbm.read_o      = r_read;
   assign wbm.read_addr_o = r_addr;
   assign wbm.read_sel_o  = r_sel;
   assign ack_o           = r_ack;
   assign color_o         = r_color;
   assign z_o             = r_z;
   assign state_o         = r_state;

endmodule

// File: tb/tb_gfx_pixel_reader64.sv
// Directed bench for gfx_pixel_reader64: table of pixel-only reads, then
// hand-written z, ignored-request, stray-ack and reset sequences.
module tb_gfx_pixel_reader64;
   import gfx_pkg::*;

   typedef struct {
      logic [2:0]  depth;
      logic [15:0] size;
      logic [15:0] x;
      logic [15:0] y;
      logic [28:0] base;
      logic [63:0] dat;
      logic [28:0] exp_addr;
      logic [7:0]  exp_sel;
      logic [31:0] exp_color;
   } vec_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [31:3]   target_base_i = '0;
   logic [31:3]   zbuffer_base_i = '0;
   logic [15:0]   target_size_x_i = '0;
   logic [2:0]    color_depth_i = '0;
   logic [15:0]   pixel_x_i = '0;
   logic [15:0]   pixel_y_i = '0;
   logic          zbuffer_enable_i = 1'b0;
   logic          read_i = 1'b0;
   logic          ack_o;
   logic [31:0]   color_o;
   logic [15:0]   z_o;
   reader_state_t state_o;

   gfx_pixel_reader64_if bus ();

   gfx_pixel_reader64 #(.point_width(16)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .target_base_i    (target_base_i),
      .zbuffer_base_i   (zbuffer_base_i),
      .target_size_x_i  (target_size_x_i),
      .color_depth_i    (color_depth_i),
      .pixel_x_i        (pixel_x_i),
      .pixel_y_i        (pixel_y_i),
      .zbuffer_enable_i (zbuffer_enable_i),
      .read_i           (read_i),
      .wbm              (bus),
      .ack_o            (ack_o),
      .color_o          (color_o),
      .z_o              (z_o),
      .state_o          (state_o)
   );

   always #5 clk_i = ~clk_i;

   int passed = 0;
   int total  = 0;
   int read_cnt = 0;
   int ack_cnt  = 0;

   always @(negedge clk_i) begin
      if (bus.read_o) read_cnt++;
      if (ack_o)      ack_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic pulse_read();
      tick();
      read_i = 1'b1;
      tick();
      read_i = 1'b0;
   endtask

   task automatic wait_read(input string name);
      logic ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus.read_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({name, "_read_seen"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_ack(input string name);
      logic ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (ack_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({name, "_ack_seen"}, 64'(ok), 64'd1);
   endtask

   task automatic send_ack(input logic [63:0] d);
      bus.ack_i = 1'b1;
      bus.dat_i = d;
      tick();
      bus.ack_i = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      target_base_i    = v.base;
      target_size_x_i  = v.size;
      color_depth_i    = v.depth;
      pixel_x_i        = v.x;
      pixel_y_i        = v.y;
      zbuffer_enable_i = 1'b0;
      ack_cnt = 0;
      pulse_read();
      wait_read(name);
      check({name, "_addr"}, 64'(bus.read_addr_o), 64'(v.exp_addr));
      check({name, "_sel"}, 64'(bus.read_sel_o), 64'(v.exp_sel));
      check({name, "_state"}, 64'(state_o), 64'(RD_PIX));
      tick();
      check({name, "_strobe_1cyc"}, 64'(bus.read_o), 64'd0);
      send_ack(v.dat);
      wait_ack(name);
      check({name, "_color"}, 64'(color_o), 64'(v.exp_color));
      check({name, "_z_zero"}, 64'(z_o), 64'd0);
      tick();
      tick();
      check({name, "_ack_count"}, 64'(ack_cnt), 64'd1);
      check({name, "_addr_hold"}, 64'(bus.read_addr_o), 64'(v.exp_addr));
   endtask

   vec_t vecs[7];
   int   rc, ac;

   initial begin
      bus.ack_i = 1'b0;
      bus.dat_i = '0;

      vecs[0] = '{DEPTH_16, 16'd640, 16'd5, 16'd2, 29'h0200_0000, 64'h1111_2222_3333_4444,
                  29'h0200_0141, 8'h0C, 32'h0000_3333};
      vecs[1] = '{DEPTH_8, 16'd640, 16'd3, 16'd0, 29'h0200_0000, 64'h8877_6655_4433_2211,
                  29'h0200_0000, 8'h08, 32'h0000_0044};
      vecs[2] = '{DEPTH_32, 16'd4, 16'd1, 16'd1, 29'h0100_0000, 64'hDEAD_BEEF_0123_4567,
                  29'h0100_0002, 8'hF0, 32'hDEAD_BEEF};
      vecs[3] = '{DEPTH_16, 16'd100, 16'd7, 16'd3, 29'h0000_0010, 64'h1234_5678_9ABC_DEF0,
                  29'h0000_005C, 8'hC0, 32'h0000_1234};
      vecs[4] = '{3'd0, 16'd640, 16'd9, 16'd9, 29'h0000_0100, 64'hCAFE_F00D_0BAD_BEEF,
                  29'h0000_0100, 8'h0F, 32'h0BAD_BEEF};
      vecs[5] = '{DEPTH_8, 16'd320, 16'd319, 16'd1, 29'h0000_0000, 64'hA1B2_C3D4_E5F6_0718,
                  29'h0000_004F, 8'h80, 32'h0000_00A1};
      vecs[6] = '{DEPTH_32, 16'd16, 16'd2, 16'd0, 29'h1FFF_FFFF, 64'h5555_5555_6666_6666,
                  29'h0000_0000, 8'h0F, 32'h6666_6666};

      // reset values
      tick();
      check("rst_read_o", 64'(bus.read_o), 64'd0);
      check("rst_addr", 64'(bus.read_addr_o), 64'd0);
      check("rst_sel", 64'(bus.read_sel_o), 64'd0);
      check("rst_ack_o", 64'(ack_o), 64'd0);
      check("rst_color", 64'(color_o), 64'd0);
      check("rst_z", 64'(z_o), 64'd0);
      check("rst_state", 64'(state_o), 64'(IDLE));
      tick();
      rst_i = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // z-buffer read following the pixel read
      target_base_i    = 29'h0200_0000;
      zbuffer_base_i   = 29'h0300_0000;
      target_size_x_i  = 16'd640;
      color_depth_i    = DEPTH_32;
      pixel_x_i        = 16'd6;
      pixel_y_i        = 16'd0;
      zbuffer_enable_i = 1'b1;
      ack_cnt = 0;
      pulse_read();
      wait_read("z_pix");
      check("z_pix_addr", 64'(bus.read_addr_o), 64'h0200_0003);
      check("z_pix_sel", 64'(bus.read_sel_o), 64'h0F);
      send_ack(64'h1122_3344_5566_7788);
      check("z_second_read", 64'(bus.read_o), 64'd1);
      check("z_addr", 64'(bus.read_addr_o), 64'h0300_0001);
      check("z_sel", 64'(bus.read_sel_o), 64'h30);
      check("z_no_early_ack", 64'(ack_o), 64'd0);
      check("z_pix_color", 64'(color_o), 64'h5566_7788);
      check("z_state", 64'(state_o), 64'(RD_Z));
      tick();
      tick();
      send_ack(64'hAAAA_BBBB_CCCC_DDDD);
      wait_ack("z");
      check("z_value", 64'(z_o), 64'hBBBB);
      check("z_color_hold", 64'(color_o), 64'h5566_7788);
      tick();
      tick();
      check("z_ack_count", 64'(ack_cnt), 64'd1);

      // a pixel-only read afterwards clears z
      apply_vec(vecs[1], "after_z");

      // read_i during RD_PIX is ignored
      apply_vec(vecs[2], "pre_ign");
      target_base_i   = vecs[0].base;
      target_size_x_i = vecs[0].size;
      color_depth_i   = vecs[0].depth;
      pixel_x_i       = vecs[0].x;
      pixel_y_i       = vecs[0].y;
      pulse_read();
      wait_read("ign");
      rc = read_cnt;
      pixel_x_i     = 16'd2;
      color_depth_i = DEPTH_8;
      read_i = 1'b1;
      tick();
      read_i = 1'b0;
      tick();
      check("ign_no_read", 64'(read_cnt - rc), 64'd0);
      check("ign_addr_hold", 64'(bus.read_addr_o), 64'(vecs[0].exp_addr));
      send_ack(vecs[0].dat);
      wait_ack("ign");
      check("ign_color", 64'(color_o), 64'(vecs[0].exp_color));

      // stray ack in IDLE
      tick();
      rc = read_cnt;
      ac = ack_cnt;
      send_ack(64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      tick();
      check("stray_no_read", 64'(read_cnt - rc), 64'd0);
      check("stray_no_ack", 64'(ack_cnt - ac), 64'd0);
      check("stray_color_hold", 64'(color_o), 64'(vecs[0].exp_color));
      check("stray_state", 64'(state_o), 64'(IDLE));

      // reset while waiting for the z data
      target_base_i    = 29'h0200_0000;
      zbuffer_base_i   = 29'h0300_0000;
      target_size_x_i  = 16'd640;
      color_depth_i    = DEPTH_32;
      pixel_x_i        = 16'd6;
      pixel_y_i        = 16'd0;
      zbuffer_enable_i = 1'b1;
      pulse_read();
      wait_read("rz_pix");
      send_ack(64'h1122_3344_5566_7788);
      check("rz_in_rd_z", 64'(state_o), 64'(RD_Z));
      rst_i = 1'b1;
      #1;
      check("rz_state", 64'(state_o), 64'(IDLE));
      check("rz_read_o", 64'(bus.read_o), 64'd0);
      check("rz_addr", 64'(bus.read_addr_o), 64'd0);
      check("rz_sel", 64'(bus.read_sel_o), 64'd0);
      check("rz_color", 64'(color_o), 64'd0);
      check("rz_z", 64'(z_o), 64'd0);
      tick();
      rst_i = 1'b0;
      zbuffer_enable_i = 1'b0;
      tick();
      ac = ack_cnt;
      send_ack(64'hAAAA_BBBB_CCCC_DDDD);
      tick();
      tick();
      check("rz_late_ack", 64'(ack_cnt - ac), 64'd0);
      check("rz_late_z", 64'(z_o), 64'd0);
      apply_vec(vecs[0], "post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
